// File: rtl/fu_logical_rs.sv
// fu_logical_rs: reservation station for the logical functional unit.
// A collapsing queue where entry 0 is always the oldest. Source operands are
// captured from CDB broadcasts, and the oldest fully ready entry is issued to
// the unit, at most one per cycle.
module fu_logical_rs #(
  parameter int DEPTH = 4,
  parameter int PRN_W = 7,
  parameter int ID_W  = 6,
  parameter int NCDB  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [31:0]                        disp_inst,
  input  logic [ID_W-1:0]                    disp_inst_id,
  input  logic [2:0][PRN_W-1:0]              disp_src_prn,
  input  logic [2:0]                         disp_src_rdy,
  input  logic [2:0][63:0]                   disp_src_data,
  input  logic [2:0][PRN_W-1:0]              disp_dst_prn,
  input  logic [NCDB-1:0]                    cdb_valid,
  input  logic [NCDB-1:0][PRN_W-1:0]         cdb_prn,
  input  logic [NCDB-1:0][63:0]              cdb_data,
  input  logic                               fu_ready,
  output logic                               iss_valid,
  output logic [31:0]                        iss_inst,
  output logic [ID_W-1:0]                    iss_inst_id,
  output logic [2:0][63:0]                   iss_op,
  output logic [2:0][PRN_W-1:0]              iss_out_prn,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0]             inst;
    logic [ID_W-1:0]         id;
    logic [2:0][PRN_W-1:0]   prn;
    logic [2:0]              rdy;
    logic [2:0][63:0]        data;
    logic [2:0][PRN_W-1:0]   dst;
  } entry_t;

  entry_t          ents  [DEPTH];
  entry_t          woke  [DEPTH];
  entry_t          ent_n [DEPTH];
  entry_t          disp_ent;
  logic [SW-1:0]   sel;
  logic            sel_found;
  logic            do_issue;
  logic            do_disp;
  int              slot;
  logic [CW-1:0]   count_n;

  // Space is judged purely on occupancy; a same-cycle issue never frees a slot for dispatch.
  assign disp_ready = (int'(count) < DEPTH);
  assign do_disp    = disp_valid && disp_ready && !flush;

  // Pick the oldest valid entry whose three sources are ready, using pre-edge state.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && (i < int'(count)) && (&ents[i].rdy)) begin
        sel       = SW'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign do_issue = fu_ready && sel_found && !flush;

  // Apply this cycle's CDB wakeups to every stored entry; scanning ports from high to low lets the lowest port win.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ents[i];
      for (int s = 0; s < 3; s++) begin
        if (!ents[i].rdy[s]) begin
          for (int k = NCDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_prn[k] == ents[i].prn[s])) begin
              woke[i].rdy[s]  = 1'b1;
              woke[i].data[s] = cdb_data[k];
            end
          end
        end
      end
    end
  end

  // Build the incoming entry, bypassing a CDB broadcast that lands on the same edge as dispatch.
  always_comb begin
    disp_ent.inst = disp_inst;
    disp_ent.id   = disp_inst_id;
    disp_ent.prn  = disp_src_prn;
    disp_ent.rdy  = disp_src_rdy;
    disp_ent.data = disp_src_data;
    disp_ent.dst  = disp_dst_prn;
    for (int s = 0; s < 3; s++) begin
      if (!disp_src_rdy[s]) begin
        for (int k = NCDB - 1; k >= 0; k--) begin
          if (cdb_valid[k] && (cdb_prn[k] == disp_src_prn[s])) begin
            disp_ent.rdy[s]  = 1'b1;
            disp_ent.data[s] = cdb_data[k];
          end
        end
      end
    end
  end

  // Collapse the queue over the issued slot and append the dispatched entry at the new tail.
  always_comb begin
    slot = int'(count) - (do_issue ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = woke[i];
    end
    if (do_issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) begin
          ent_n[i] = woke[i+1];
        end
      end
    end
    if (do_disp) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == slot) begin
          ent_n[i] = disp_ent;
        end
      end
    end
  end

  assign count_n = count + CW'(do_disp) - CW'(do_issue);

  // Entry storage: cleared on reset. Flush empties the queue by zeroing the count, so stale contents never become visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ents[i] <= '0;
      end
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ents[i] <= ent_n[i];
      end
    end
  end

  // Occupancy and the registered issue port; the issue fields hold their last value between issues.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= '0;
      iss_valid   <= 1'b0;
      iss_inst    <= '0;
      iss_inst_id <= '0;
      iss_op      <= '0;
      iss_out_prn <= '0;
    end else if (flush) begin
      count     <= '0;
      iss_valid <= 1'b0;
    end else begin
      count     <= count_n;
      iss_valid <= do_issue;
      if (do_issue) begin
        iss_inst    <= ents[sel].inst;
        iss_inst_id <= ents[sel].id;
        iss_op      <= ents[sel].data;
        iss_out_prn <= ents[sel].dst;
      end
    end
  end

endmodule

// File: tb/tb_fu_logical_rs.sv
// Directed bench for fu_logical_rs: issue latency, out-of-order issue on wakeup,
// dispatch bypass, full queue behaviour, flush, and reset in mid-operation.
module tb_fu_logical_rs;

  localparam int DEPTH = 4;
  localparam int PRN_W = 7;
  localparam int ID_W  = 6;
  localparam int NCDB  = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         flush;
  logic                         disp_valid;
  logic                         disp_ready;
  logic [31:0]                  disp_inst;
  logic [ID_W-1:0]              disp_inst_id;
  logic [2:0][PRN_W-1:0]        disp_src_prn;
  logic [2:0]                   disp_src_rdy;
  logic [2:0][63:0]             disp_src_data;
  logic [2:0][PRN_W-1:0]        disp_dst_prn;
  logic [NCDB-1:0]              cdb_valid;
  logic [NCDB-1:0][PRN_W-1:0]   cdb_prn;
  logic [NCDB-1:0][63:0]        cdb_data;
  logic                         fu_ready;
  logic                         iss_valid;
  logic [31:0]                  iss_inst;
  logic [ID_W-1:0]              iss_inst_id;
  logic [2:0][63:0]             iss_op;
  logic [2:0][PRN_W-1:0]        iss_out_prn;
  logic [2:0]                   count;

  int n_checks = 0;
  int n_errors = 0;

  fu_logical_rs #(.DEPTH(DEPTH), .PRN_W(PRN_W), .ID_W(ID_W), .NCDB(NCDB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst(disp_inst), .disp_inst_id(disp_inst_id),
    .disp_src_prn(disp_src_prn), .disp_src_rdy(disp_src_rdy),
    .disp_src_data(disp_src_data), .disp_dst_prn(disp_dst_prn),
    .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_data(cdb_data),
    .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_inst(iss_inst), .iss_inst_id(iss_inst_id),
    .iss_op(iss_op), .iss_out_prn(iss_out_prn), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load an all-ready instruction; operands and destinations are derived from the id.
  task automatic set_disp(input logic [ID_W-1:0] id);
    disp_valid       = 1'b1;
    disp_inst        = 32'hAA00_0000 | 32'(id);
    disp_inst_id     = id;
    disp_src_rdy     = 3'b111;
    disp_src_prn[0]  = 7'd1;
    disp_src_prn[1]  = 7'd2;
    disp_src_prn[2]  = 7'd3;
    disp_src_data[0] = 64'h100 + 64'(id);
    disp_src_data[1] = 64'h200 + 64'(id);
    disp_src_data[2] = 64'h300 + 64'(id);
    disp_dst_prn[0]  = 7'd40;
    disp_dst_prn[1]  = 7'd0;
    disp_dst_prn[2]  = 7'd41;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    flush      = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; fu_ready = 1'b0;
    disp_inst = '0; disp_inst_id = '0; disp_src_prn = '0; disp_src_rdy = '0;
    disp_src_data = '0; disp_dst_prn = '0; cdb_valid = '0; cdb_prn = '0; cdb_data = '0;
    tick(); tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_op0", iss_op[0], 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);

    // ORR with all sources ready issues one edge after dispatch
    set_disp(6'd3);
    disp_inst = 32'hAA02_0020;
    disp_src_data[0] = 64'hF0;
    disp_src_data[1] = 64'h0F;
    disp_src_data[2] = 64'h0;
    fu_ready = 1'b1;
    tick();
    chk("orr_count_after_disp", 64'(count), 64'd1);
    chk("orr_no_issue_yet", 64'(iss_valid), 64'd0);
    idle();
    tick();
    chk("orr_iss_valid", 64'(iss_valid), 64'd1);
    chk("orr_op0", iss_op[0], 64'hF0);
    chk("orr_op1", iss_op[1], 64'h0F);
    chk("orr_id", 64'(iss_inst_id), 64'd3);
    chk("orr_inst", 64'(iss_inst), 64'hAA02_0020);
    chk("orr_dst0", 64'(iss_out_prn[0]), 64'd40);
    chk("orr_dst2", 64'(iss_out_prn[2]), 64'd41);
    chk("orr_count_empty", 64'(count), 64'd0);
    tick();
    chk("orr_pulse_low", 64'(iss_valid), 64'd0);
    chk("orr_op0_hold", iss_op[0], 64'hF0);

    // Younger ready instruction overtakes an older one waiting on prn 9
    fu_ready = 1'b0;
    set_disp(6'd10);
    disp_src_prn[1] = 7'd9;
    disp_src_rdy = 3'b101;
    tick();
    set_disp(6'd11);
    tick();
    chk("ooo_count2", 64'(count), 64'd2);
    idle();
    fu_ready = 1'b1;
    tick();
    chk("ooo_b_valid", 64'(iss_valid), 64'd1);
    chk("ooo_b_first", 64'(iss_inst_id), 64'd11);
    chk("ooo_count1", 64'(count), 64'd1);
    // both ports hit prn 9: port 0 must win
    cdb_valid = 2'b11;
    cdb_prn[0] = 7'd9; cdb_data[0] = 64'h1234;
    cdb_prn[1] = 7'd9; cdb_data[1] = 64'h9999;
    tick();
    chk("ooo_wake_not_same_edge", 64'(iss_valid), 64'd0);
    idle();
    tick();
    chk("ooo_a_valid", 64'(iss_valid), 64'd1);
    chk("ooo_a_id", 64'(iss_inst_id), 64'd10);
    chk("ooo_a_op1", iss_op[1], 64'h1234);
    chk("ooo_a_op0", iss_op[0], 64'h10A);
    chk("ooo_count0", 64'(count), 64'd0);

    // Dispatch bypass from CDB port 1 on the same edge
    set_disp(6'd20);
    disp_src_prn[0] = 7'd5;
    disp_src_rdy = 3'b110;
    cdb_valid = 2'b10;
    cdb_prn[0] = 7'd5; cdb_data[0] = 64'hDEAD;
    cdb_prn[1] = 7'd5; cdb_data[1] = 64'hABCD;
    tick();
    idle();
    tick();
    chk("byp_valid", 64'(iss_valid), 64'd1);
    chk("byp_id", 64'(iss_inst_id), 64'd20);
    chk("byp_op0", iss_op[0], 64'hABCD);

    // Fill the queue, then drain it in order
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_disp(6'(30 + i));
      tick();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_not_ready", 64'(disp_ready), 64'd0);
    set_disp(6'd34);
    tick();
    chk("full_extra_ignored", 64'(count), 64'd4);
    fu_ready = 1'b1;
    tick();
    chk("full_no_bypass_count", 64'(count), 64'd3);
    chk("drain0_id", 64'(iss_inst_id), 64'd30);
    idle();
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_valid", 64'(iss_valid), 64'd1);
      chk("drain_id", 64'(iss_inst_id), 64'(30 + i));
    end
    tick();
    chk("drain_done_valid", 64'(iss_valid), 64'd0);
    chk("drain_done_count", 64'(count), 64'd0);

    // Flush with a concurrent dispatch discards everything
    fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(6'(40 + i));
      tick();
    end
    chk("flush_pre_count", 64'(count), 64'd3);
    set_disp(6'd43);
    flush = 1'b1;
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_iss_valid", 64'(iss_valid), 64'd0);
    idle();
    fu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_issue", 64'(iss_valid), 64'd0);
    end

    // Streaming dispatch with issue on the same edge keeps the count at one
    for (int i = 0; i < 3; i++) begin
      set_disp(6'(60 + i));
      tick();
      chk("stream_count", 64'(count), 64'd1);
      if (i > 0) chk("stream_id", 64'(iss_inst_id), 64'(60 + i - 1));
    end
    idle();
    tick();
    chk("stream_last_id", 64'(iss_inst_id), 64'd62);
    chk("stream_last_count", 64'(count), 64'd0);

    // Reset in mid-operation
    fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(6'(50 + i));
      tick();
    end
    idle();
    fu_ready = 1'b1;
    tick();
    chk("mid_iss_valid", 64'(iss_valid), 64'd1);
    chk("mid_count", 64'(count), 64'd2);
    rst = 1'b0;
    tick();
    chk("mrst_iss_valid", 64'(iss_valid), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_inst", 64'(iss_inst), 64'd0);
    chk("mrst_id", 64'(iss_inst_id), 64'd0);
    chk("mrst_op0", iss_op[0], 64'd0);
    chk("mrst_op1", iss_op[1], 64'd0);
    chk("mrst_op2", iss_op[2], 64'd0);
    chk("mrst_out_prn", 64'(iss_out_prn), 64'd0);
    rst = 1'b1;
    tick();
    chk("mrst_stays_empty", 64'(iss_valid), 64'd0);
    chk("mrst_disp_ready", 64'(disp_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fu_logical_rs.md
# fu_logical_rs

Reservation station in front of the logical functional unit. Holds up to DEPTH dispatched logical-class instructions, captures source operand values from common-data-bus (CDB) broadcasts, and issues the oldest fully-ready entry to the unit, one per cycle, when the unit reports ready. Sits between rename/dispatch and the logical FU.

## Interface
Parameters:
- DEPTH, 4: entry count (2..16).
- PRN_W, 7: physical register number width.
- ID_W, 6: instruction id (ROB tag) width.
- NCDB, 2: number of CDB broadcast ports.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- flush  in  1  discard all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  space available; combinational, = (count < DEPTH).
- disp_inst  in  32  instruction word.
- disp_inst_id  in  ID_W  instruction id.
- disp_src_prn  in  3 x PRN_W  sources: [0] Xn, [1] Xm, [2] flags.
- disp_src_rdy  in  3  source value already valid (unused sources dispatched with rdy=1).
- disp_src_data  in  3 x 64  source value when rdy=1.
- disp_dst_prn  in  3 x PRN_W  destination PRNs (data, unused, flags).
- cdb_valid  in  NCDB  broadcast valid.
- cdb_prn  in  NCDB x PRN_W  broadcast PRN.
- cdb_data  in  NCDB x 64  broadcast value.
- fu_ready  in  1  unit accepts an instruction this cycle.
- iss_valid  out  1  issue strobe (maps to FU inst_valid); registered.
- iss_inst  out  32; iss_inst_id  out  ID_W; iss_op  out  3 x 64; iss_out_prn  out  3 x PRN_W; all registered.
- count  out  clog2(DEPTH+1)  occupied entries.

## Operation
- Collapsing queue: entry 0 is oldest; valid entries contiguous from 0.
- Entry fields: inst, inst_id, 3 x {prn, rdy, data}, 3 x dst prn. Entry ready = all three rdy.
- Dispatch accepted when disp_valid && disp_ready && !flush; written at slot count, or count-1 if an issue occurs same edge.
- Wakeup: every valid entry source with rdy=0 and prn == cdb_prn[k] with cdb_valid[k] sets rdy=1, data=cdb_data[k]. Lowest k wins on multiple matches. Sources already rdy ignore CDB.
- Same-edge dispatch bypass: a dispatched source with rdy=0 whose prn matches a valid CDB port that cycle is written rdy=1 with the CDB data.
- Issue select: lowest-index ready entry, evaluated on pre-edge state (wakeups of this edge not visible). If fu_ready and one exists: iss_* <= its fields, iss_valid <= 1, entry removed, higher entries shift down one. Otherwise iss_valid <= 0; iss_* hold.
- Shifting entries also apply this edge's wakeups.
- count updates: +1 dispatch, -1 issue, net 0 when both; flush -> 0.
- flush: all entries invalid, iss_valid <= 0, dispatch that cycle dropped.

## Timing
- Reset (rst=0 at edge): count=0, all entries invalid, iss_valid=0, iss_inst=0, iss_inst_id=0, iss_op=0, iss_out_prn=0. disp_ready=1 after reset.
- Minimum latency: dispatch at edge N with all sources ready -> iss_valid high after edge N+1.
- Wakeup at edge N -> entry issuable at edge N+1.
- Full (count=DEPTH): disp_ready=0 even if an issue occurs same cycle (no full-bypass).
- iss_valid is a single-cycle pulse per issued instruction; back-to-back issues on consecutive cycles allowed.
- Priority at an edge: rst > flush > issue/wakeup/dispatch (concurrent).

## Test plan
- Reset then dispatch ORR (inst 0xAA020020, all rdy, op0=0xF0, op1=0x0F, id=3), fu_ready=1 -> iss_valid one cycle later, iss_op[0]=0xF0, iss_op[1]=0x0F, iss_inst_id=3, count back to 0.
- Dispatch A (src1 prn 9 not ready) then B (ready); fu_ready=1 -> B issues first; cdb prn 9 = 0x1234 -> A issues next edge with iss_op[1]=0x1234.
- Dispatch with src0 prn 5 not ready while cdb_valid[1] prn 5 data 0xABCD same cycle -> entry issues next edge with iss_op[0]=0xABCD.
- Fill 4 entries with fu_ready=0 -> disp_ready=0, count=4; extra disp_valid ignored; raise fu_ready -> 4 issues on 4 consecutive cycles in dispatch order.
- Fill 3 entries, assert flush same cycle as dispatch -> count=0, iss_valid=0, no issue afterwards.
- rst=0 mid-operation with 2 entries and iss_valid=1 -> next cycle all outputs zero, count=0.
